// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered data.
// Ports: Clk, Rst (async high), Load/DataIn stage BCD data, BlankEn, DpMask; drives Anode, Segments, Dp, Pending, FrameDone.
module display_scan_ctrl #(
    parameter int DIVIDER = 49999
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic [15:0] DataIn,
    input  logic        BlankEn,
    input  logic [3:0]  DpMask,
    output logic [3:0]  Anode,
    output logic [6:0]  Segments,
    output logic        Dp,
    output logic        Pending,
    output logic        FrameDone
);

    localparam int CW = (DIVIDER < 1) ? 1 : $clog2(DIVIDER + 1);
    localparam logic [CW-1:0] TERM = CW'(DIVIDER);

    logic [CW-1:0] count;
    logic          tick;
    logic [1:0]    idx;
    logic [15:0]   staging;
    logic [15:0]   display;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_code;
    logic          wrap;

    assign tick  = (count == TERM);
    assign wrap  = tick && (idx == 2'd3);
    assign digit = display[{idx, 2'b00} +: 4];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // A digit is blanked only when it and every digit above it are zero.
    always_comb begin
        blank = 1'b0;
        if (BlankEn) begin
            unique case (idx)
                2'd3:    blank = (display[15:12] == 4'd0);
                2'd2:    blank = (display[15:8] == 8'd0);
                2'd1:    blank = (display[15:4] == 12'd0);
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        seg_code = 7'h3F;
        unique case (digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h3F;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Anode     <= 4'hF;
            Segments  <= 7'h7F;
            Dp        <= 1'b1;
            FrameDone <= 1'b0;
        end else begin
            FrameDone <= wrap;
            if (tick) begin
                Anode    <= blank ? 4'hF : ~(4'b0001 << idx);
                Segments <= blank ? 7'h7F : seg_code;
                Dp       <= blank | ~DpMask[idx];
            end
        end
    end

    // The display register only changes at a frame wrap, so a frame is
    // never shown half old and half new. A Load on the wrap edge re-arms
    // Pending with the fresh value while the older staged value goes live.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            staging <= 16'h0000;
            display <= 16'h0000;
            Pending <= 1'b0;
        end else begin
            if (wrap && Pending) begin
                display <= staging;
                Pending <= 1'b0;
            end
            if (Load) begin
                staging <= DataIn;
                Pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with DIVIDER=2.
// Directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_display_scan_ctrl;

    localparam int DIV = 2;

    logic        Clk;
    logic        Rst;
    logic        Load;
    logic [15:0] DataIn;
    logic        BlankEn;
    logic [3:0]  DpMask;
    logic [3:0]  Anode;
    logic [6:0]  Segments;
    logic        Dp;
    logic        Pending;
    logic        FrameDone;

    int n_pass;
    int n_total;

    display_scan_ctrl #(.DIVIDER(DIV)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Load(Load),
        .DataIn(DataIn),
        .BlankEn(BlankEn),
        .DpMask(DpMask),
        .Anode(Anode),
        .Segments(Segments),
        .Dp(Dp),
        .Pending(Pending),
        .FrameDone(FrameDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model: cycles since reset decide the ticks, tick count
    // modulo 4 gives the digit, shifts pick nibbles.
    logic [6:0]  lut [16];
    int          m_cyc;
    int          m_ticks;
    int          pos;
    logic [15:0] m_stage;
    logic [15:0] m_disp;
    logic        m_pend;
    logic [3:0]  e_anode;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
    logic        e_blank;

    initial begin
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    end

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_cyc   = 0;
            m_ticks = 0;
            m_stage = 16'h0;
            m_disp  = 16'h0;
            m_pend  = 1'b0;
            e_anode = 4'hF;
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
            e_fd    = 1'b0;
            e_blank = 1'b0;
        end else begin
            e_fd = 1'b0;
            if ((m_cyc % (DIV + 1)) == DIV) begin
                pos     = m_ticks % 4;
                e_blank = BlankEn && (pos > 0) && ((m_disp >> (4 * pos)) == 16'h0);
                e_anode = e_blank ? 4'hF : (4'hF ^ (4'b0001 << pos));
                e_seg   = e_blank ? 7'h7F : lut[int'((m_disp >> (4 * pos)) & 16'hF)];
                e_dp    = e_blank || !DpMask[pos];
                e_fd    = (pos == 3);
                if (pos == 3 && m_pend) begin
                    m_disp = m_stage;
                    m_pend = 1'b0;
                end
                m_ticks++;
            end
            m_cyc++;
            if (Load) begin
                m_stage = DataIn;
                m_pend  = 1'b1;
            end
        end
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge Clk) begin
        check("m_anode", {12'h0, Anode}, {12'h0, e_anode});
        if (!e_blank) check("m_seg", {9'h0, Segments}, {9'h0, e_seg});
        check("m_dp", {15'h0, Dp}, {15'h0, e_dp});
        check("m_pend", {15'h0, Pending}, {15'h0, m_pend});
        check("m_fd", {15'h0, FrameDone}, {15'h0, e_fd});
    end

    task automatic step(int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic chk_reset(string tag);
        check({tag, "_anode"}, {12'h0, Anode}, 16'h000F);
        check({tag, "_seg"}, {9'h0, Segments}, 16'h007F);
        check({tag, "_dp"}, {15'h0, Dp}, 16'h1);
        check({tag, "_pend"}, {15'h0, Pending}, 16'h0);
        check({tag, "_fd"}, {15'h0, FrameDone}, 16'h0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        Rst     = 1'b1;
        Load    = 1'b0;
        DataIn  = 16'h0;
        BlankEn = 1'b0;
        DpMask  = 4'h0;
        #12;
        chk_reset("rst");
        step(1);
        Rst = 1'b0;

        // first tick on the 3rd edge, then every 3 edges
        step(3);
        check("t1_anode", {12'h0, Anode}, 16'h000E);
        check("t1_seg", {9'h0, Segments}, 16'h0040);
        step(1);
        check("hold_anode", {12'h0, Anode}, 16'h000E);
        step(2);
        check("t2_anode", {12'h0, Anode}, 16'h000D);
        step(3);
        check("t3_anode", {12'h0, Anode}, 16'h000B);
        step(3);
        check("t4_anode", {12'h0, Anode}, 16'h0007);
        check("t4_fd", {15'h0, FrameDone}, 16'h1);
        step(1);
        check("t4_fd_off", {15'h0, FrameDone}, 16'h0);
        step(2);
        check("t5_anode", {12'h0, Anode}, 16'h000E);

        // load 1234 while index is 1
        Load   = 1'b1;
        DataIn = 16'h1234;
        step(1);
        Load   = 1'b0;
        DataIn = 16'h0;
        check("ld_pend", {15'h0, Pending}, 16'h1);
        step(2);
        check("ld_old_seg", {9'h0, Segments}, 16'h0040);
        step(6);
        check("ld_fd", {15'h0, FrameDone}, 16'h1);
        check("ld_pend_clr", {15'h0, Pending}, 16'h0);
        step(3);
        check("ld_new_seg", {9'h0, Segments}, 16'h0019);

        // blanking and decimal point with 0050
        Load   = 1'b1;
        DataIn = 16'h0050;
        step(1);
        Load    = 1'b0;
        BlankEn = 1'b1;
        DpMask  = 4'b0100;
        step(5);
        check("dp_anode", {12'h0, Anode}, 16'h000B);
        check("dp_on", {15'h0, Dp}, 16'h0);
        check("d2_seg", {9'h0, Segments}, 16'h0024);
        step(6);
        check("bl_d0_seg", {9'h0, Segments}, 16'h0040);
        check("bl_d0_dp", {15'h0, Dp}, 16'h1);
        step(3);
        check("bl_d1_seg", {9'h0, Segments}, 16'h0012);
        check("bl_d1_anode", {12'h0, Anode}, 16'h000D);
        step(3);
        check("bl_d2_anode", {12'h0, Anode}, 16'h000F);
        check("bl_d2_dp", {15'h0, Dp}, 16'h1);
        step(3);
        check("bl_d3_anode", {12'h0, Anode}, 16'h000F);

        // collision: AAAA pending, 9999 loaded on the wrap edge
        Load   = 1'b1;
        DataIn = 16'hAAAA;
        step(1);
        Load = 1'b0;
        step(10);
        Load   = 1'b1;
        DataIn = 16'h9999;
        step(1);
        Load = 1'b0;
        check("col_fd", {15'h0, FrameDone}, 16'h1);
        check("col_pend", {15'h0, Pending}, 16'h1);
        step(3);
        check("col_dash", {9'h0, Segments}, 16'h003F);
        check("col_anode", {12'h0, Anode}, 16'h000E);
        step(9);
        check("col_pend_clr", {15'h0, Pending}, 16'h0);
        step(3);
        check("col_nine", {9'h0, Segments}, 16'h0010);

        // reset pulse between edges while pending
        Load   = 1'b1;
        DataIn = 16'h5678;
        step(1);
        Load = 1'b0;
        check("rp_pend", {15'h0, Pending}, 16'h1);
        #4;
        Rst = 1'b1;
        #1;
        chk_reset("rp");
        #1;
        Rst = 1'b0;
        step(3);
        check("rp_anode", {12'h0, Anode}, 16'h000E);
        check("rp_seg", {9'h0, Segments}, 16'h0040);
        step(12);
        check("rp_stale_seg", {9'h0, Segments}, 16'h0040);
        check("rp_stale_pend", {15'h0, Pending}, 16'h0);

        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 900; i++) begin
            step(1);
            Rst  = ($urandom_range(0, 299) == 0);
            Load = ($urandom_range(0, 7) == 0);
            for (int d = 0; d < 4; d++) begin
                DataIn[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 39) == 0) BlankEn = ~BlankEn;
            if ($urandom_range(0, 29) == 0) DpMask = 4'($urandom_range(0, 15));
        end
        Rst  = 1'b0;
        Load = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
